// File: rtl/vpu_operand_dispatch_pkg.sv
// Shared constants, FSM state type and row-masking helper for the VPU operand dispatcher.
package vpu_operand_dispatch_pkg;

  localparam int OPERAND_WIDTH = 8;
  localparam int VLANE_CNT     = 4;
  localparam int SRC_CNT       = 3;
  localparam int DATA_W        = OPERAND_WIDTH * VLANE_CNT;
  localparam int CNT_W         = 8;
  localparam int BEAT_W        = SRC_CNT * DATA_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } dispatch_state_t;

  // Zero the slice of every source that is not enabled for this instruction.
  function automatic logic [BEAT_W-1:0] mask_rows(input logic [BEAT_W-1:0]  rows,
                                                  input logic [SRC_CNT-1:0] mask);
    logic [BEAT_W-1:0] res;
    res = '0;
    for (int k = 0; k < SRC_CNT; k++) begin
      if (mask[k]) res[k*DATA_W +: DATA_W] = rows[k*DATA_W +: DATA_W];
    end
    return res;
  endfunction

endpackage

// File: rtl/vpu_operand_dispatch_if.sv
// Source-queue read port plus operand-beat handshake between the dispatcher and its neighbours.
interface vpu_operand_dispatch_if;
  import vpu_operand_dispatch_pkg::*;

  logic [SRC_CNT-1:0] src_rdempty_i;
  logic [BEAT_W-1:0]  src_rdata_i;
  logic [SRC_CNT-1:0] src_rden_o;

  // Beat transfers on a cycle with op_valid_o && op_ready_i. Once raised, op_valid_o,
  // op_data_o and op_last_o hold until that transfer; op_ready_i may toggle freely.
  logic               op_valid_o;
  logic               op_ready_i;
  logic [BEAT_W-1:0]  op_data_o;
  logic               op_last_o;

  modport master (
    input  src_rdempty_i, src_rdata_i, op_ready_i,
    output src_rden_o, op_valid_o, op_data_o, op_last_o
  );

  modport slave (
    output src_rdempty_i, src_rdata_i, op_ready_i,
    input  src_rden_o, op_valid_o, op_data_o, op_last_o
  );

endinterface

// File: rtl/vpu_operand_dispatch_out_reg.sv
// One-entry valid/ready pipeline register carrying an operand beat and its last flag.
module vpu_dispatch_out_reg
  import vpu_operand_dispatch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              load,
  input  logic [BEAT_W-1:0] in_data,
  input  logic              in_last,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [BEAT_W-1:0] out_data,
  output logic              out_last
);

  // A load in the same cycle as a transfer overwrites the entry, so there is no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_last  <= in_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/vpu_operand_dispatch.sv
// Pops all enabled source queues in lock-step and issues operand beats to the lanes.
// Optional stall counters: define VPU_DISPATCH_PERF_EN.
module vpu_operand_dispatch
  import vpu_operand_dispatch_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [SRC_CNT-1:0]   src_mask_i,
  input  logic [CNT_W-1:0]     beat_cnt_i,
  input  logic                 abort_i,
  output logic                 busy_o,
  output logic                 done_o,
  output dispatch_state_t      state_o,
`ifdef VPU_DISPATCH_PERF_EN
  output logic [31:0]          stall_src_o,
  output logic [31:0]          stall_lane_o,
`endif
  vpu_operand_dispatch_if.master bus
);

  dispatch_state_t    state_q, state_d;
  logic [SRC_CNT-1:0] mask_q;
  logic [CNT_W-1:0]   remain_q;
  logic               done_q;
  logic               avail, out_free, pop, accept, start_ok;

  assign avail    = &(~bus.src_rdempty_i | ~mask_q);
  assign out_free = !bus.op_valid_o || bus.op_ready_i;
  assign pop      = (state_q == RUN) && avail && out_free && !abort_i;
  assign accept   = bus.op_valid_o && bus.op_ready_i;
  assign start_ok = (state_q == IDLE) && start_i && !abort_i;

  assign bus.src_rden_o = pop ? mask_q : '0;
  assign busy_o         = (state_q != IDLE);
  assign done_o         = done_q;
  assign state_o        = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok && (beat_cnt_i != '0)) state_d = RUN;
      RUN:     if (pop && (remain_q == CNT_W'(1))) state_d = DRAIN;
      DRAIN:   if (accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_i) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      remain_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= !abort_i && ((start_ok && (beat_cnt_i == '0)) ||
                              ((state_q == DRAIN) && accept));
      if (start_ok) begin
        mask_q   <= src_mask_i;
        remain_q <= beat_cnt_i;
      end else if (pop) begin
        remain_q <= remain_q - CNT_W'(1);
      end
    end
  end

  vpu_dispatch_out_reg u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .flush     (abort_i),
    .load      (pop),
    .in_data   (mask_rows(bus.src_rdata_i, mask_q)),
    .in_last   (remain_q == CNT_W'(1)),
    .out_ready (bus.op_ready_i),
    .out_valid (bus.op_valid_o),
    .out_data  (bus.op_data_o),
    .out_last  (bus.op_last_o)
  );

`ifdef VPU_DISPATCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      stall_src_o  <= '0;
      stall_lane_o <= '0;
    end else begin
      if ((state_q == RUN) && !avail && (stall_src_o != '1))
        stall_src_o <= stall_src_o + 32'd1;
      if ((state_q != IDLE) && bus.op_valid_o && !bus.op_ready_i && (stall_lane_o != '1))
        stall_lane_o <= stall_lane_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vpu_operand_dispatch.sv
// Self-checking bench for vpu_operand_dispatch: queue-based source model plus beat scoreboard.
module tb_vpu_operand_dispatch;
  import vpu_operand_dispatch_pkg::*;

  localparam int W = BEAT_W;

  logic               clk;
  logic               rst;
  logic               start;
  logic [SRC_CNT-1:0] mask;
  logic [CNT_W-1:0]   cnt;
  logic               abort;
  logic               busy;
  logic               done;
  dispatch_state_t    state;
`ifdef VPU_DISPATCH_PERF_EN
  logic [31:0]        stall_src;
  logic [31:0]        stall_lane;
`endif

  vpu_operand_dispatch_if vif ();

  vpu_operand_dispatch dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start),
    .src_mask_i (mask),
    .beat_cnt_i (cnt),
    .abort_i    (abort),
    .busy_o     (busy),
    .done_o     (done),
    .state_o    (state),
`ifdef VPU_DISPATCH_PERF_EN
    .stall_src_o  (stall_src),
    .stall_lane_o (stall_lane),
`endif
    .bus        (vif.master)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // source queues (environment) and expected-beat scoreboard
  logic [DATA_W-1:0] src_q [SRC_CNT][$];
  logic [W-1:0]      exp_q [$];

  // behavioural model of the dispatcher
  bit                m_busy, m_valid, m_last, m_done;
  int                m_left;
  logic [W-1:0]      m_data;
  logic [SRC_CNT-1:0] m_mask;
  longint            m_ss, m_sl;

  int n_tests, n_fail, cyc;
  int done_cnt, done_cyc, beats, last_flags, first_cyc, last_cyc, last_flag_cyc;
  logic [W-1:0] beat_log [$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_src();
    for (int k = 0; k < SRC_CNT; k++) begin
      vif.src_rdempty_i[k] = (src_q[k].size() == 0);
      vif.src_rdata_i[k*DATA_W +: DATA_W] = (src_q[k].size() != 0) ? src_q[k][0] : $urandom;
    end
  endtask

  task automatic clear_q();
    for (int k = 0; k < SRC_CNT; k++) src_q[k].delete();
  endtask

  task automatic reset_stats();
    beats = 0; last_flags = 0; first_cyc = -1; last_cyc = -1; last_flag_cyc = -1;
    beat_log.delete();
  endtask

  // One clock: settle inputs, compare against the model, advance the model at the edge.
  task automatic step();
    logic [W-1:0] bundle;
    bit avail, pop, acc_m;
    drive_src();
    #1;
    cyc++;
    if (rst) begin
      chk("rst_busy", W'(busy), W'(0));
      chk("rst_done", W'(done), W'(0));
      chk("rst_valid", W'(vif.op_valid_o), W'(0));
      chk("rst_last", W'(vif.op_last_o), W'(0));
      chk("rst_rden", W'(vif.src_rden_o), W'(0));
      chk("rst_data", vif.op_data_o, W'(0));
      m_busy = 0; m_valid = 0; m_last = 0; m_done = 0; m_left = 0; m_data = '0; m_mask = '0;
      m_ss = 0; m_sl = 0;
      exp_q.delete();
      @(posedge clk);
      @(negedge clk);
      return;
    end
    avail = 1; bundle = '0;
    for (int k = 0; k < SRC_CNT; k++) begin
      if (m_mask[k]) begin
        if (src_q[k].size() == 0) avail = 0;
        else bundle[k*DATA_W +: DATA_W] = src_q[k][0];
      end
    end
    pop = m_busy && (m_left > 0) && avail && (!m_valid || vif.op_ready_i) && !abort;
    chk("busy", W'(busy), W'(m_busy));
    chk("done", W'(done), W'(m_done));
    chk("op_valid", W'(vif.op_valid_o), W'(m_valid));
    chk("rden", W'(vif.src_rden_o), pop ? W'(m_mask) : W'(0));
    if (m_valid) begin
      chk("op_data", vif.op_data_o, m_data);
      chk("op_last", W'(vif.op_last_o), W'(m_last));
    end
`ifdef VPU_DISPATCH_PERF_EN
    chk("stall_src", W'(stall_src), W'(m_ss));
    chk("stall_lane", W'(stall_lane), W'(m_sl));
`endif
    if (vif.op_valid_o && vif.op_ready_i) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", W'(1), W'(0));
      end else begin
        chk("beat_order", vif.op_data_o, exp_q.pop_front());
      end
      beats++;
      beat_log.push_back(vif.op_data_o);
      if (first_cyc < 0) first_cyc = cyc;
      last_cyc = cyc;
      if (vif.op_last_o) begin
        last_flags++;
        last_flag_cyc = cyc;
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    @(posedge clk);
    if (m_busy && (m_left > 0) && !avail && m_ss < 64'hFFFF_FFFF) m_ss++;
    if (m_busy && m_valid && !vif.op_ready_i && m_sl < 64'hFFFF_FFFF) m_sl++;
    acc_m = m_valid && vif.op_ready_i;
    if (abort) begin
      m_busy = 0; m_valid = 0; m_left = 0; m_done = 0;
      exp_q.delete();
    end else begin
      m_done = 0;
      if (!m_busy && start) begin
        m_mask = mask; m_ss = 0; m_sl = 0;
        if (cnt == 0) m_done = 1;
        else begin
          m_busy = 1;
          m_left = int'(cnt);
        end
      end else if (pop) begin
        m_data = bundle; m_last = (m_left == 1); m_valid = 1; m_left--;
        exp_q.push_back(bundle);
        for (int k = 0; k < SRC_CNT; k++) if (m_mask[k]) void'(src_q[k].pop_front());
      end else if (acc_m) begin
        m_valid = 0;
        if (m_last) begin
          m_busy = 0;
          m_done = 1;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic wait_done(input int max_cyc);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < max_cyc && done_cnt == d0; i++) step();
    chk("wait_done_timeout", W'(done_cnt > d0), W'(1));
  endtask

  task automatic begin_instr(input logic [SRC_CNT-1:0] m, input logic [CNT_W-1:0] c);
    mask = m; cnt = c; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    int d0, s0;
    n_tests = 0; n_fail = 0; cyc = 0; done_cnt = 0; done_cyc = -1;
    rst = 1'b1; start = 1'b0; mask = '0; cnt = '0; abort = 1'b0;
    vif.op_ready_i = 1'b0;
    reset_stats();
    drive_src();
    @(negedge clk);
    repeat (3) step();
    rst = 1'b0;
    step();

    // two sources, four beats, lanes always ready
    clear_q(); reset_stats();
    for (int i = 0; i < 4; i++) begin
      src_q[0].push_back(32'hA000_0000 + i);
      src_q[1].push_back(32'hB000_0000 + i);
      src_q[2].push_back(32'hC000_0000 + i);
    end
    vif.op_ready_i = 1'b1;
    begin_instr(3'b011, 8'd4);
    wait_done(20);
    chk("t1_beats", W'(beats), W'(4));
    chk("t1_back_to_back", W'(last_cyc - first_cyc), W'(3));
    chk("t1_last_on_beat4", W'(last_flag_cyc), W'(last_cyc));
    chk("t1_last_count", W'(last_flags), W'(1));
    chk("t1_done_latency", W'(done_cyc - last_cyc), W'(1));
    chk("t1_beat0", beat_log[0], 96'h00000000_B0000000_A0000000);
    chk("t1_beat3", beat_log[3], 96'h00000000_B0000003_A0000003);
    chk("t1_src2_untouched", W'(src_q[2].size()), W'(4));
    step();

    // one queue empty for five cycles
    clear_q(); reset_stats();
    for (int i = 0; i < 2; i++) begin
      src_q[0].push_back(32'h1000_0000 + i);
      src_q[1].push_back(32'h2000_0000 + i);
    end
    begin_instr(3'b111, 8'd2);
    repeat (5) step();
    chk("t2_no_beats", W'(beats), W'(0));
    chk("t2_no_pop", W'(src_q[0].size()), W'(2));
    for (int i = 0; i < 2; i++) src_q[2].push_back(32'h3000_0000 + i);
    wait_done(20);
    chk("t2_beats", W'(beats), W'(2));
    chk("t2_beat1", beat_log[1], 96'h30000001_20000001_10000001);

    // lane back-pressure mid-stream
    clear_q(); reset_stats();
    for (int i = 0; i < 3; i++) begin
      src_q[0].push_back(32'h4000_0000 + i);
      src_q[1].push_back(32'h5000_0000 + i);
      src_q[2].push_back(32'h6000_0000 + i);
    end
    vif.op_ready_i = 1'b1;
    begin_instr(3'b111, 8'd3);
    step(); step();
    vif.op_ready_i = 1'b0;
    repeat (4) step();
    chk("t3_stall_no_pop", W'(src_q[0].size()), W'(1));
    vif.op_ready_i = 1'b1;
    wait_done(20);
    chk("t3_beats", W'(beats), W'(3));
    chk("t3_beat2", beat_log[2], 96'h60000002_50000002_40000002);

    // zero-beat instruction
    clear_q(); reset_stats();
    d0 = done_cnt; s0 = cyc;
    begin_instr(3'b111, 8'd0);
    step();
    chk("t4_done_once", W'(done_cnt - d0), W'(1));
    chk("t4_done_next", W'(done_cyc - s0), W'(2));
    step();

    // abort mid-instruction, then a fresh one-beat instruction
    clear_q(); reset_stats();
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < SRC_CNT; k++) src_q[k].push_back($urandom);
    begin_instr(3'b111, 8'd8);
    for (int i = 0; i < 20 && beats < 3; i++) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    d0 = done_cnt;
    repeat (5) step();
    chk("t5_no_done", W'(done_cnt - d0), W'(0));
    chk("t5_idle", W'(busy), W'(0));
    clear_q(); reset_stats();
    for (int k = 0; k < SRC_CNT; k++) src_q[k].push_back(32'h7000_0000 + k);
    begin_instr(3'b111, 8'd1);
    wait_done(20);
    chk("t5_beats", W'(beats), W'(1));
    chk("t5_last", W'(last_flags), W'(1));
    chk("t5_beat0", beat_log[0], 96'h70000002_70000001_70000000);

    // randomized traffic
    for (int n = 0; n < 30; n++) begin
      begin_instr(3'($urandom_range(0, 7)), 8'($urandom_range(0, 6)));
      for (int c = 0; c < 300 && (m_busy || m_done); c++) begin
        for (int k = 0; k < SRC_CNT; k++)
          if ($urandom_range(0, 1) == 1 && src_q[k].size() < 8) src_q[k].push_back($urandom);
        vif.op_ready_i = ($urandom_range(0, 3) != 0);
        abort = ($urandom_range(0, 79) == 0);
        start = m_busy && ($urandom_range(0, 7) == 0);
        mask = 3'($urandom_range(0, 7));
        cnt = 8'($urandom_range(0, 6));
        step();
      end
      abort = 1'b0; start = 1'b0; vif.op_ready_i = 1'b1;
      chk("rand_idle", W'(busy), W'(0));
    end

`ifdef VPU_DISPATCH_PERF_EN
    clear_q(); reset_stats();
    vif.op_ready_i = 1'b1;
    begin_instr(3'b001, 8'd2);
    step(); step();
    src_q[0].push_back(32'h8000_0000);
    src_q[0].push_back(32'h8000_0001);
    vif.op_ready_i = 1'b0;
    step();
    repeat (3) step();
    vif.op_ready_i = 1'b1;
    wait_done(20);
    chk("perf_stall_src", W'(stall_src), W'(2));
    chk("perf_stall_lane", W'(stall_lane), W'(3));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
